// File: rtl/ascon_perm_seq.sv
// Sequential Ascon permutation: one S-box cycle per round followed by the sigma
// linear layer, either time-shared over the lanes (SHARED_SIGMA=1) or fully parallel.

module ascon_sigma (
   input  logic [63:0] x,
   input  logic [5:0]  rot_a,
   input  logic [5:0]  rot_b,
   output logic [63:0] y
);
   logic [63:0] ra, rb;

   // Rotation amounts are never 0, and a 64-bit left shift by 64 yields 0 anyway.
   assign ra = (x >> rot_a) | (x << (7'd64 - {1'b0, rot_a}));
   assign rb = (x >> rot_b) | (x << (7'd64 - {1'b0, rot_b}));
   assign y  = x ^ ra ^ rb;
endmodule

module ascon_perm_seq #(
   parameter int SHARED_SIGMA = 1
) (
   input  logic         ise_clk,
   input  logic         ise_rst,
   input  logic         req_val,
   output logic         req_rdy,
   input  logic [3:0]   req_rounds,
   input  logic [319:0] req_state,
   output logic         rsp_val,
   input  logic         rsp_rdy,
   output logic [319:0] rsp_state,
   output logic         rsp_err,
   output logic         busy
);
   localparam int NUM_LANES = 5;
   localparam int VEC_W     = 64;

   localparam logic [5:0] ROT_A [NUM_LANES] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
   localparam logic [5:0] ROT_B [NUM_LANES] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

   typedef enum logic [1:0] {IDLE, SBOX, LIN, DONE} state_t;

   state_t state, state_nxt;

   logic [NUM_LANES-1:0][VEC_W-1:0] st, sbox_out, lin_out, sx, tt;
   logic [3:0] r, cnt;
   logic [2:0] lane;
   logic       err_q;
   logic       legal;
   logic       lin_last;

   assign legal = (req_rounds != 4'd0) && (req_rounds <= 4'd12);

   // Bitsliced S-box with the round constant folded into x2 first.
   always_comb begin
      sx = st;
      tt = '0;
      sx[2] = sx[2] ^ {56'd0, 4'hF - r, r};
      sx[0] = sx[0] ^ sx[4];
      sx[4] = sx[4] ^ sx[3];
      sx[2] = sx[2] ^ sx[1];
      for (int i = 0; i < NUM_LANES; i++)
         tt[i] = ~sx[i] & sx[(i + 1) % NUM_LANES];
      for (int i = 0; i < NUM_LANES; i++)
         sx[i] = sx[i] ^ tt[(i + 1) % NUM_LANES];
      sx[1] = sx[1] ^ sx[0];
      sx[0] = sx[0] ^ sx[4];
      sx[3] = sx[3] ^ sx[2];
      sx[2] = ~sx[2];
      sbox_out = sx;
   end

   generate
      if (SHARED_SIGMA != 0) begin : g_shared
         logic [63:0] sig_in, sig_out;
         logic [5:0]  rot_a, rot_b;

         always_comb begin
            sig_in = st[0];
            rot_a  = ROT_A[0];
            rot_b  = ROT_B[0];
            for (int i = 1; i < NUM_LANES; i++) begin
               if (lane == 3'(i)) begin
                  sig_in = st[i];
                  rot_a  = ROT_A[i];
                  rot_b  = ROT_B[i];
               end
            end
         end

         ascon_sigma u_sigma (.x(sig_in), .rot_a(rot_a), .rot_b(rot_b), .y(sig_out));

         always_comb begin
            lin_out = st;
            for (int i = 0; i < NUM_LANES; i++)
               if (lane == 3'(i)) lin_out[i] = sig_out;
         end

         assign lin_last = (lane == 3'd4);
      end else begin : g_par
         for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            ascon_sigma u_sigma (.x(st[i]), .rot_a(ROT_A[i]), .rot_b(ROT_B[i]), .y(lin_out[i]));
         end
         assign lin_last = 1'b1;
      end
   endgenerate

   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (req_val) state_nxt = legal ? SBOX : DONE;
         SBOX: state_nxt = LIN;
         LIN:  if (lin_last) state_nxt = (cnt == 4'd1) ? DONE : SBOX;
         DONE: if (rsp_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         st    <= '0;
         r     <= '0;
         cnt   <= '0;
         lane  <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_val) begin
                  st    <= req_state;
                  r     <= 4'd12 - req_rounds;
                  cnt   <= req_rounds;
                  lane  <= '0;
                  err_q <= ~legal;
               end
            end
            SBOX: st <= sbox_out;
            LIN: begin
               st   <= lin_out;
               lane <= lin_last ? 3'd0 : lane + 3'd1;
               if (lin_last) begin
                  r   <= r + 4'd1;
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: if (rsp_rdy) err_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign req_rdy   = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_val   = (state == DONE);
   assign rsp_state = rsp_val ? st : '0;
   assign rsp_err   = rsp_val & err_q;
endmodule

// File: doc/ascon_perm_seq.md
ASCON_PERM_SEQ -- requirements
Module: ascon_perm_seq

Interface
REQ-001 SHALL have parameter SHARED_SIGMA, default 1: 1 = one sigma linear-layer unit time-shared over the five lanes; 0 = five parallel sigma units.
REQ-002 SHALL have port ise_clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port ise_rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_val, input, 1: permutation request valid.
REQ-005 SHALL have port req_rdy, output, 1: controller can accept a request.
REQ-006 SHALL have port req_rounds, input, 4: round count n.
REQ-007 SHALL have port req_state, input, 320: input state, lane xi at bits [64i+63:64i], i = 0..4.
REQ-008 SHALL have port rsp_val, output, 1: result valid.
REQ-009 SHALL have port rsp_rdy, input, 1: consumer accepts the result.
REQ-010 SHALL have port rsp_state, output, 320: result state, same lane packing as req_state.
REQ-011 SHALL have port rsp_err, output, 1: request had an illegal n; valid only while rsp_val is high.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM IDLE -> SBOX -> LIN -> (SBOX | DONE) -> IDLE.
REQ-014 SHALL drive req_rdy high only in IDLE.
REQ-015 SHALL treat a cycle with req_val and req_rdy both high at a rising edge as an accept, and on that edge register req_state, set round index r = 12 - n and the round counter to n, and enter SBOX.
REQ-016 SHALL treat n in 1..12 as legal; for n = 0 or n > 12 it SHALL go from IDLE directly to DONE, return rsp_state equal to req_state, and set rsp_err = 1.
REQ-017 In SBOX it SHALL XOR the constant c_r = {4'hF - r, r[3:0]}, zero-extended to 64 bits, into x2.
REQ-018 In the same SBOX cycle it SHALL apply the bitsliced Ascon S-box: x0^=x4, x4^=x3, x2^=x1; then ti = ~xi & x(i+1 mod 5); then xi ^= t(i+1 mod 5); then x1^=x0, x0^=x4, x3^=x2, x2 = ~x2.
REQ-019 SBOX SHALL take 1 cycle and then go to LIN.
REQ-020 In LIN it SHALL compute sigma_i(x) = x ^ ror(x,a) ^ ror(x,b) with (a,b) per lane: x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
REQ-021 With SHARED_SIGMA=1, LIN SHALL use a 3-bit lane counter running 0..4, update one lane per cycle, and take 5 cycles.
REQ-022 With SHARED_SIGMA=0, LIN SHALL update all lanes in 1 cycle.
REQ-023 At the end of LIN it SHALL increment r and decrement the round counter; if the counter reaches 0 it SHALL go to DONE, else to SBOX.
REQ-024 SHALL give a latency from the accept edge to the first rsp_val-high cycle of n*6 cycles (SHARED_SIGMA=1) or n*2 cycles (SHARED_SIGMA=0), and exactly 1 cycle for an illegal n.
REQ-025 In DONE it SHALL drive rsp_val = 1 and hold rsp_state and rsp_err stable until rsp_rdy = 1.
REQ-026 The edge that completes rsp_val and rsp_rdy SHALL return the FSM to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-027 SHALL ignore req_val while busy, with no change to internal state.
REQ-028 SHALL drive rsp_state to 0 whenever rsp_val = 0.
REQ-029 SHALL use modulo-64 rotations, with no carries or widening.

Reset
REQ-030 On ise_rst = 0 it SHALL immediately, without a clock, force the FSM to IDLE, clear the state, r, the round counter and the lane counter, and drive req_rdy = 1, rsp_val = 0, rsp_err = 0, busy = 0 and rsp_state = 0.
REQ-031 Reset asserted mid-permutation SHALL discard the operation; after release the block SHALL accept a new request with no residual state.

Verification
REQ-032 Bench SHALL cover: zero state, n = 12, SHARED_SIGMA=1 -> rsp_val exactly 72 cycles after accept; rsp_state equals a software Ascon p12 golden model; rsp_err = 0.
REQ-033 Bench SHALL cover: same stimulus with SHARED_SIGMA=0 -> result identical to REQ-032, latency 24 cycles.
REQ-034 Bench SHALL cover: n = 6 and n = 8 on random states, compared against the p6 and p8 golden models, where the first constant is 0x96 (n=6) and 0xB4 (n=8).
REQ-035 Bench SHALL cover: n = 0 and n = 13 -> rsp_val after 1 cycle, rsp_state = req_state, rsp_err = 1.
REQ-036 Bench SHALL cover: rsp_rdy held low for 10 cycles -> rsp_val and rsp_state stable, req_rdy = 0, and req_val pulses ignored; then rsp_rdy = 1 -> IDLE on the next cycle.
REQ-037 Bench SHALL cover: ise_rst pulsed low during LIN of round 3 -> outputs reach their reset values without a clock; the next request of n = 12 gives the golden p12 result.
